// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO shadow checker: mismatch bit positions,
// the mismatch vector type and the occupancy width helper.
package fifo_chk_pkg;

  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_ACK   = 1;
  localparam int unsigned ERR_OVF   = 2;
  localparam int unsigned ERR_UDF   = 3;
  localparam int unsigned ERR_FULL  = 4;
  localparam int unsigned ERR_EMPTY = 5;
  localparam int unsigned ERR_AF    = 6;
  localparam int unsigned ERR_AE    = 7;

  typedef logic [7:0] err_vec_t;

  // Width needed to hold an entry count of 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow of the synchronous FIFO: storage, pointers, entry
// count and the registered values the real FIFO is expected to present.
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  localparam int unsigned CW        = count_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_wr_ack,
  output logic                  exp_overflow,
  output logic                  exp_underflow,
  output logic                  exp_rd,
  output logic                  exp_full,
  output logic                  exp_empty,
  output logic                  exp_af,
  output logic                  exp_ae,
  output logic                  cmp_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Pointers wrap by compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status derived from the current count; these are also the expected flags.
  always_comb begin
    exp_full  = (count == CW'(DEPTH));
    exp_empty = (count == '0);
    exp_af    = (count == CW'(AF_LEVEL));
    exp_ae    = (count == CW'(AE_LEVEL));
    wr_ok     = wr_en & ~exp_full;
    rd_ok     = rd_en & ~exp_empty;
  end

  // Shadow storage; contents are only observable after a write, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= data_in;
  end

  // Pointers, count and expected registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      exp_data      <= '0;
      exp_wr_ack    <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      exp_rd        <= 1'b0;
      cmp_valid     <= 1'b0;
    end else begin
      cmp_valid     <= 1'b1;
      exp_wr_ack    <= wr_ok;
      exp_overflow  <= wr_en & exp_full;
      exp_underflow <= rd_en & exp_empty;
      exp_rd        <= rd_ok;
      if (rd_ok) begin
        exp_data <= mem[rd_ptr];
        rd_ptr   <= bump(rd_ptr);
      end
      if (wr_ok) wr_ptr <= bump(wr_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_shadow_checker.sv
// In-line FIFO checker: compares the DUT outputs each cycle against the
// shadow model and keeps saturating pass/fail totals plus sticky error flags.
module fifo_shadow_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned OCC_W     = count_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic [OCC_W-1:0]      occupancy,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  err_pulse,
  output err_vec_t              err_flags,
  output err_vec_t              first_err
);

  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_wr_ack;
  logic                  exp_overflow;
  logic                  exp_underflow;
  logic                  exp_rd;
  logic                  exp_full;
  logic                  exp_empty;
  logic                  exp_af;
  logic                  exp_ae;
  logic                  cmp_valid;
  err_vec_t              mismatch;

  fifo_ref_model #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_model (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .count         (occupancy),
    .exp_data      (exp_data),
    .exp_wr_ack    (exp_wr_ack),
    .exp_overflow  (exp_overflow),
    .exp_underflow (exp_underflow),
    .exp_rd        (exp_rd),
    .exp_full      (exp_full),
    .exp_empty     (exp_empty),
    .exp_af        (exp_af),
    .exp_ae        (exp_ae),
    .cmp_valid     (cmp_valid)
  );

  // Per-field mismatch; read data only matters on a cycle that delivered a word.
  always_comb begin
    mismatch            = '0;
    mismatch[ERR_DATA]  = exp_rd && (data_out != exp_data);
    mismatch[ERR_ACK]   = (wr_ack      != exp_wr_ack);
    mismatch[ERR_OVF]   = (overflow    != exp_overflow);
    mismatch[ERR_UDF]   = (underflow   != exp_underflow);
    mismatch[ERR_FULL]  = (full        != exp_full);
    mismatch[ERR_EMPTY] = (empty       != exp_empty);
    mismatch[ERR_AF]    = (almostfull  != exp_af);
    mismatch[ERR_AE]    = (almostempty != exp_ae);
  end

  // Saturating totals, one-cycle error pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      correct_count <= '0;
      error_count   <= '0;
      err_pulse     <= 1'b0;
      err_flags     <= '0;
      first_err     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (chk_en && cmp_valid) begin
        if (mismatch == '0) begin
          if (correct_count != '1) correct_count <= correct_count + CNT_WIDTH'(1);
        end else begin
          if (error_count != '1) error_count <= error_count + CNT_WIDTH'(1);
          err_pulse <= 1'b1;
          err_flags <= err_flags | mismatch;
          if (first_err == '0) first_err <= mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Directed bench for fifo_shadow_checker. A small behavioural FIFO stands in
// for the checked DUT (with switchable faults); checker outputs are compared
// against hand-computed constants.
module tb_fifo_shadow_checker;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        chk_en;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_in;

  // Stand-in FIFO outputs
  logic [15:0] dq;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic        force_dead;
  logic        fault_ack;

  // Checker outputs, 16-bit counters
  logic [3:0]  occupancy;
  logic [15:0] correct_count, error_count;
  logic        err_pulse;
  logic [7:0]  err_flags, first_err;

  // Checker outputs, 4-bit counters
  logic [3:0]  occupancy4;
  logic [3:0]  correct_count4, error_count4;
  logic        err_pulse4;
  logic [7:0]  err_flags4, first_err4;

  int n_assert = 0;
  int n_fail   = 0;

  assign data_out = force_dead ? 16'hDEAD : dq;

  // Stand-in FIFO: unbounded accept/deliver tallies over a circular store.
  logic [15:0] store [64];
  int unsigned wcnt, rcnt, fill;
  logic        acc_w, acc_r;
  int unsigned fill_nx;

  assign fill    = wcnt - rcnt;
  assign acc_w   = wr_en && (fill < DEPTH);
  assign acc_r   = rd_en && (fill != 0);
  assign fill_nx = fill + 32'(acc_w) - 32'(acc_r);

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0; rcnt <= 0; dq <= '0;
      wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
      full <= 1'b0; empty <= 1'b1; almostfull <= 1'b0; almostempty <= 1'b0;
    end else begin
      wcnt <= wcnt + 32'(acc_w);
      rcnt <= rcnt + 32'(acc_r);
      if (acc_w) store[wcnt[5:0]] <= data_in;
      if (acc_r) dq <= store[rcnt[5:0]];
      wr_ack      <= acc_w || (fault_ack && wr_en && fill == DEPTH);
      overflow    <= wr_en && (fill == DEPTH) && !fault_ack;
      underflow   <= rd_en && (fill == 0);
      full        <= (fill_nx == DEPTH);
      empty       <= (fill_nx == 0);
      almostfull  <= (fill_nx == DEPTH - 1);
      almostempty <= (fill_nx == 1);
    end
  end

  fifo_shadow_checker #(
    .DATA_WIDTH (16),
    .DEPTH      (8),
    .AF_LEVEL   (7),
    .AE_LEVEL   (1),
    .CNT_WIDTH  (16)
  ) dut (
    .clk (clk), .rst (rst), .chk_en (chk_en), .wr_en (wr_en), .rd_en (rd_en),
    .data_in (data_in), .data_out (data_out), .wr_ack (wr_ack),
    .overflow (overflow), .underflow (underflow), .full (full), .empty (empty),
    .almostfull (almostfull), .almostempty (almostempty),
    .occupancy (occupancy), .correct_count (correct_count),
    .error_count (error_count), .err_pulse (err_pulse),
    .err_flags (err_flags), .first_err (first_err)
  );

  fifo_shadow_checker #(
    .DATA_WIDTH (16),
    .DEPTH      (8),
    .AF_LEVEL   (7),
    .AE_LEVEL   (1),
    .CNT_WIDTH  (4)
  ) dut4 (
    .clk (clk), .rst (rst), .chk_en (chk_en), .wr_en (wr_en), .rd_en (rd_en),
    .data_in (data_in), .data_out (data_out), .wr_ack (wr_ack),
    .overflow (overflow), .underflow (underflow), .full (full), .empty (empty),
    .almostfull (almostfull), .almostempty (almostempty),
    .occupancy (occupancy4), .correct_count (correct_count4),
    .error_count (error_count4), .err_pulse (err_pulse4),
    .err_flags (err_flags4), .first_err (first_err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive request inputs, let one rising edge pass, return at the falling edge.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(negedge clk);
  endtask

  // Reset edge, then one idle edge that arms the compare; every later step
  // contributes exactly one compare.
  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    force_dead = 1'b0; fault_ack = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 16'h0);

    // Reset state
    check("rst_occ",    32'(occupancy),      0);
    check("rst_cc",     32'(correct_count),  0);
    check("rst_ec",     32'(error_count),    0);
    check("rst_pulse",  32'(err_pulse),      0);
    check("rst_flags",  32'(err_flags),      0);
    check("rst_first",  32'(first_err),      0);
    check("rst_occ4",   32'(occupancy4),     0);
    check("rst_cc4",    32'(correct_count4), 0);
    check("rst_ec4",    32'(error_count4),   0);
    check("rst_pulse4", 32'(err_pulse4),     0);
    check("rst_flags4", 32'(err_flags4),     0);
    check("rst_first4", 32'(first_err4),     0);

    // Idle: first edge after reset arms, next five edges compare
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("arm_cc", 32'(correct_count), 0);
    repeat (5) step(1'b0, 1'b0, 16'h0);
    check("idle5_cc",  32'(correct_count),  5);
    check("idle5_ec",  32'(error_count),    0);
    check("idle5_occ", 32'(occupancy),      0);
    check("idle5_cc4", 32'(correct_count4), 5);
    repeat (15) step(1'b0, 1'b0, 16'h0);
    check("idle20_cc",  32'(correct_count),  20);
    check("sat_cc4",    32'(correct_count4), 15);
    check("sat_ec4",    32'(error_count4),   0);

    // Fill past full, then drain past empty
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i));
    check("fill4_occ", 32'(occupancy), 4);
    for (int i = 5; i <= 9; i++) step(1'b1, 1'b0, 16'(i));
    check("fill9_occ", 32'(occupancy), 8);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0);
    check("drain_occ", 32'(occupancy), 0);
    step(1'b0, 1'b0, 16'h0);
    check("fd_ec",    32'(error_count),   0);
    check("fd_cc",    32'(correct_count), 19);
    check("fd_flags", 32'(err_flags),     0);

    // Simultaneous read/write while full, then while empty
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h10 + i));
    check("sim_full_occ", 32'(occupancy), 8);
    step(1'b1, 1'b1, 16'h00AA);
    check("sim_rw_full_occ", 32'(occupancy), 7);
    repeat (7) step(1'b0, 1'b1, 16'h0);
    check("sim_empty_occ", 32'(occupancy), 0);
    step(1'b1, 1'b1, 16'h00BB);
    check("sim_rw_empty_occ", 32'(occupancy), 1);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("sim_end_occ", 32'(occupancy),     0);
    check("sim_ec",      32'(error_count),   0);
    check("sim_cc",      32'(correct_count), 19);

    // Faulty DUT acknowledges a write while full: ack and overflow mismatch
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h20 + i));
    fault_ack = 1'b1;
    step(1'b1, 1'b0, 16'h0099);
    fault_ack = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("ack_pulse",  32'(err_pulse),     1);
    check("ack_ec",     32'(error_count),   1);
    check("ack_cc",     32'(correct_count), 9);
    check("ack_bit1",   32'(err_flags[1]),  1);
    check("ack_flags",  32'(err_flags),     32'h06);
    check("ack_first",  32'(first_err),     32'h06);
    step(1'b0, 1'b0, 16'h0);
    check("ack_pulse_off", 32'(err_pulse), 0);

    // Corrupted data on the third read
    do_reset();
    step(1'b1, 1'b0, 16'h0011);
    step(1'b1, 1'b0, 16'h0022);
    step(1'b1, 1'b0, 16'h0033);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    force_dead = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    force_dead = 1'b0;
    check("dead_pulse", 32'(err_pulse),     1);
    check("dead_ec",    32'(error_count),   1);
    check("dead_cc",    32'(correct_count), 6);
    check("dead_flags", 32'(err_flags),     32'h01);
    check("dead_first", 32'(first_err),     32'h01);
    step(1'b0, 1'b0, 16'h0);
    check("dead_pulse_off", 32'(err_pulse), 0);
    check("dead_flags_hold", 32'(err_flags), 32'h01);

    // Bad data on a cycle without a read is ignored
    force_dead = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    force_dead = 1'b0;
    check("nord_ec", 32'(error_count),   1);
    check("nord_cc", 32'(correct_count), 8);

    // chk_en low suppresses a real data mismatch; the model keeps tracking
    step(1'b1, 1'b0, 16'h0044);
    step(1'b0, 1'b1, 16'h0);
    force_dead = 1'b1;
    chk_en     = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    force_dead = 1'b0;
    chk_en     = 1'b1;
    check("chkoff_ec",    32'(error_count),   1);
    check("chkoff_cc",    32'(correct_count), 10);
    check("chkoff_pulse", 32'(err_pulse),     0);
    check("chkoff_occ",   32'(occupancy),     0);
    step(1'b0, 1'b0, 16'h0);
    check("chkon_cc", 32'(correct_count), 11);

    // Reset mid-stream discards held data and suppresses that cycle's compare
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h50 + i));
    check("mid_pre_occ", 32'(occupancy), 5);
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0066);
    check("mid_occ",   32'(occupancy),     0);
    check("mid_cc",    32'(correct_count), 0);
    check("mid_ec",    32'(error_count),   0);
    check("mid_flags", 32'(err_flags),     0);
    rst = 1'b0;
    step(1'b0, 1'b1, 16'h0);
    check("mid_arm_cc", 32'(correct_count), 0);
    check("mid_arm_occ", 32'(occupancy),    0);
    step(1'b0, 1'b0, 16'h0);
    check("mid_udf_cc", 32'(correct_count), 1);
    check("mid_udf_ec", 32'(error_count),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
